// File: rtl/batch_lookahead_reverser_if.sv
`default_nettype none
// ============================================================================
//  Module   : batch_lookahead_reverser_if
//  Brief    : Stream and batch-index bundle between the lookahead reverser
//             and the backward-recursion datapath.
//  Revision : 1.0
// ============================================================================
interface batch_lookahead_reverser_if #(
    parameter int N     = 4,
    parameter int DSR   = 1,
    parameter int DEPTH = 32
);
    localparam int c_W  = N * DSR;
    localparam int c_BD = (DEPTH + DSR - 1) / DSR;
    localparam int c_CW = (c_BD > 1) ? $clog2(c_BD) : 1;

    logic              in_valid;
    logic [c_W-1:0]    in_data;
    logic [c_W-1:0]    out_data;
    logic              out_valid;
    logic              out_last;
    logic [c_CW-1:0]   dBatCount;
    logic [c_CW-1:0]   dBatCountRev;
    logic              cyclePulse;
    logic              bank;

    modport slave (
        input  in_valid, in_data,
        output out_data, out_valid, out_last, dBatCount, dBatCountRev, cyclePulse, bank
    );

    modport master (
        output in_valid, in_data,
        input  out_data, out_valid, out_last, dBatCount, dBatCountRev, cyclePulse, bank
    );
endinterface
`default_nettype wire

// File: rtl/batch_lookahead_reverser.sv
`default_nettype none
// ============================================================================
//  Module   : batch_lookahead_reverser
//  Brief    : Ping-pong batch store; replays the previous batch in reverse,
//             one word per accepted input word.
//  Revision : 1.0
// ============================================================================
module batch_lookahead_reverser #(
    parameter int N     = 4,
    parameter int DSR   = 1,
    parameter int DEPTH = 32
) (
    input  wire                          clk,
    input  wire                          rst_n,
    batch_lookahead_reverser_if.slave    bus
);
    localparam int c_W  = N * DSR;
    localparam int c_BD = (DEPTH + DSR - 1) / DSR;
    localparam int c_CW = (c_BD > 1) ? $clog2(c_BD) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_BD - 1);

    logic [c_W-1:0]  r_mem [2][c_BD];
    logic [c_CW-1:0] r_cnt;
    logic            r_bank;
    logic            r_primed;
    logic [c_W-1:0]  r_out_data;
    logic            r_out_valid;
    logic            r_out_last;
    logic            r_pulse;

    logic            w_at_last;
    logic [c_CW-1:0] w_rd_idx;

    assign w_at_last = (r_cnt == c_LAST);
    assign w_rd_idx  = c_LAST - r_cnt;

    // Storage is not reset; its contents only matter once a full batch is in.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            r_mem[r_bank][r_cnt] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_bank      <= 1'b0;
            r_primed    <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_pulse     <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid && r_primed;
            r_out_last  <= bus.in_valid && r_primed && w_at_last;
            r_pulse     <= bus.in_valid && w_at_last;
            if (bus.in_valid) begin
                // Read side uses the bank and index as they were before this edge.
                if (r_primed) begin
                    r_out_data <= r_mem[~r_bank][w_rd_idx];
                end
                if (w_at_last) begin
                    r_cnt    <= '0;
                    r_bank   <= ~r_bank;
                    r_primed <= 1'b1;
                end else begin
                    r_cnt    <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.out_data     = r_out_data;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_last     = r_out_last;
    assign bus.dBatCount    = r_cnt;
    assign bus.dBatCountRev = w_rd_idx;
    assign bus.cyclePulse   = r_pulse;
    assign bus.bank         = r_bank;
endmodule
`default_nettype wire

// File: tb/tb_batch_lookahead_reverser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_batch_lookahead_reverser
//  Brief    : Directed and random checks of the lookahead reverser against a
//             batch-level reference model with an output scoreboard.
//  Revision : 1.0
// ============================================================================
module tb_batch_lookahead_reverser;
    localparam int c_BD = 8;

    logic clk;
    logic rst_n;
    int   n_asserts;
    int   n_fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    batch_lookahead_reverser_if #(.N(4), .DSR(1), .DEPTH(8)) bus1 ();
    batch_lookahead_reverser_if #(.N(4), .DSR(2), .DEPTH(7)) bus2 ();

    batch_lookahead_reverser #(.N(4), .DSR(1), .DEPTH(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    batch_lookahead_reverser #(.N(4), .DSR(2), .DEPTH(7)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct packed {
        logic [3:0] data;
        logic       last;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_cur [c_BD];
    logic [3:0] m_prev[c_BD];
    int         m_cnt;
    int         m_bank;
    bit         m_primed;
    logic [3:0] m_last_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt      = 0;
        m_bank     = 0;
        m_primed   = 1'b0;
        m_last_out = 4'h0;
        sb_q.delete();
    endtask

    // Reset asserted between edges so its effect is visibly asynchronous.
    task automatic pulse_reset();
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        check("rst_out_last",  32'(bus1.out_last),  32'd0);
        check("rst_out_data",  32'(bus1.out_data),  32'd0);
        check("rst_count",     32'(bus1.dBatCount), 32'd0);
        check("rst_count_rev", 32'(bus1.dBatCountRev), 32'(c_BD - 1));
        check("rst_pulse",     32'(bus1.cyclePulse), 32'd0);
        check("rst_bank",      32'(bus1.bank), 32'd0);
        check("rst2_count_rev", 32'(bus2.dBatCountRev), 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit v, input logic [3:0] d);
        bit   exp_valid;
        bit   exp_pulse;
        exp_t e;
        exp_valid = v && m_primed;
        exp_pulse = v && (m_cnt == c_BD - 1);
        if (exp_valid) sb_q.push_back('{data: m_prev[c_BD - 1 - m_cnt], last: (m_cnt == c_BD - 1)});
        if (v) begin
            m_cur[m_cnt] = d;
            if (m_cnt == c_BD - 1) begin
                m_prev   = m_cur;
                m_cnt    = 0;
                m_bank   = 1 - m_bank;
                m_primed = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        @(negedge clk);
        bus1.in_valid = v;
        bus1.in_data  = d;
        @(posedge clk);
        #1;
        check("out_valid", 32'(bus1.out_valid), 32'(exp_valid));
        if (exp_valid) begin
            if (sb_q.size() == 0) begin
                check("scoreboard_empty", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                m_last_out = e.data;
                check("out_data", 32'(bus1.out_data), 32'(e.data));
                check("out_last", 32'(bus1.out_last), 32'(e.last));
            end
        end else begin
            check("out_data_hold", 32'(bus1.out_data), 32'(m_last_out));
            check("out_last_idle", 32'(bus1.out_last), 32'd0);
        end
        check("dBatCount",    32'(bus1.dBatCount),    32'(m_cnt));
        check("dBatCountRev", 32'(bus1.dBatCountRev), 32'(c_BD - 1 - m_cnt));
        check("cyclePulse",   32'(bus1.cyclePulse),   32'(exp_pulse));
        check("bank",         32'(bus1.bank),         32'(m_bank));
    endtask

    task automatic step2(input logic [7:0] d, input bit ev, input logic [7:0] ed,
                         input bit el, input int ecnt, input bit epulse);
        @(negedge clk);
        bus2.in_valid = 1'b1;
        bus2.in_data  = d;
        @(posedge clk);
        #1;
        check("c2_out_valid", 32'(bus2.out_valid), 32'(ev));
        if (ev) check("c2_out_data", 32'(bus2.out_data), 32'(ed));
        check("c2_out_last",  32'(bus2.out_last),  32'(el));
        check("c2_count",     32'(bus2.dBatCount), 32'(ecnt));
        check("c2_count_rev", 32'(bus2.dBatCountRev), 32'(3 - ecnt));
        check("c2_pulse",     32'(bus2.cyclePulse), 32'(epulse));
    endtask

    initial begin
        int accepted;
        bit v;
        n_asserts     = 0;
        n_fails       = 0;
        rst_n         = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.in_data  = '0;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;
        model_reset();
        pulse_reset();

        // First batch: nothing comes out, pulse and bank flip on the 8th word.
        for (int i = 0; i < 8; i++) step(1'b1, 4'(i));

        // Second batch with a 3-cycle gap at index 3.
        for (int i = 8; i < 11; i++) step(1'b1, 4'(i));
        for (int i = 0; i < 3; i++) step(1'b0, 4'hF);
        for (int i = 11; i < 16; i++) step(1'b1, 4'(i));

        // Third batch interrupted by reset at index 5.
        for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 3));
        pulse_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 4'($urandom_range(0, 15)));

        // Four batches with random idle cycles.
        accepted = 0;
        while (accepted < 4 * c_BD) begin
            v = ($urandom_range(0, 3) != 0);
            step(v, 4'($urandom_range(0, 15)));
            if (v) accepted++;
        end
        step(1'b0, 4'h0);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        // Depth 7, DSR 2: four 8-bit words per batch.
        bus1.in_valid = 1'b0;
        step2(8'hA1, 1'b0, 8'h00, 1'b0, 1, 1'b0);
        step2(8'hB2, 1'b0, 8'h00, 1'b0, 2, 1'b0);
        step2(8'hC3, 1'b0, 8'h00, 1'b0, 3, 1'b0);
        step2(8'hD4, 1'b0, 8'h00, 1'b0, 0, 1'b1);
        check("c2_bank", 32'(bus2.bank), 32'd1);
        step2(8'h01, 1'b1, 8'hD4, 1'b0, 1, 1'b0);
        step2(8'h02, 1'b1, 8'hC3, 1'b0, 2, 1'b0);
        step2(8'h03, 1'b1, 8'hB2, 1'b0, 3, 1'b0);
        step2(8'h04, 1'b1, 8'hA1, 1'b1, 0, 1'b1);
        step2(8'h05, 1'b1, 8'h04, 1'b0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
